// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider: FSM encoding, default widths,
// and the divide-by-zero quotient fill.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_DW_DEFAULT = 32;
  localparam int DIV_CW_DEFAULT = 7;

  // Divide-by-zero quotient is all-ones; replicated to 2*DW at the use site.
  localparam logic DBZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the resulting quotient bit.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW:0]   p_i,
  input  logic          bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW:0]   p_o,
  output logic          q_o
);

  logic [DW:0] p_shift;
  logic [DW:0] dvs_ext;

  assign p_shift = {p_i[DW-1:0], bit_i};
  assign dvs_ext = {1'b0, divisor_i};
  assign q_o     = (p_shift >= dvs_ext);
  assign p_o     = q_o ? (p_shift - dvs_ext) : p_shift;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, 2*DW / DW, one quotient bit per cycle; results
// registered on done. Optional SEQ_DIVIDER_EARLY_OUT_EN finishes in one cycle when dividend < divisor.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW_DEFAULT,
  parameter int CW = DIV_CW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero
);

  localparam logic [CW-1:0] LAST_CNT = CW'(2*DW-1);

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [DW:0]     p_q;
  logic [2*DW-1:0] q_q;
  logic [DW-1:0]   dvs_q;
  logic            busy_q;
  logic            done_q;
  logic            dbz_q;
  logic [2*DW-1:0] quot_q;
  logic [DW-1:0]   rem_q;

  logic [DW:0]     p_d;
  logic            qbit_d;
  logic [2*DW-1:0] q_d;
  logic            early_out;

  div_step #(.DW(DW)) u_step (
    .p_i      (p_q),
    .bit_i    (q_q[2*DW-1]),
    .divisor_i(dvs_q),
    .p_o      (p_d),
    .q_o      (qbit_d)
  );

  assign q_d = {q_q[2*DW-2:0], qbit_d};

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  assign early_out = (divisor != '0) && ({{DW{1'b0}}, divisor} > dividend);
`else
  assign early_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvs_q  <= divisor;
            busy_q <= 1'b1;
            if (divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= {(2*DW){DBZ_QUOT_BIT}};
              rem_q   <= dividend[DW-1:0];
              dbz_q   <= 1'b1;
            end else if (early_out) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= '0;
              rem_q   <= dividend[DW-1:0];
              dbz_q   <= 1'b0;
            end else begin
              state_q <= CALC;
              p_q     <= '0;
              q_q     <= dividend;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
            end
          end
        end
        CALC: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          // The last step's result goes straight to the output registers.
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= p_d[DW-1:0];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
